wm_ddr_rd_master: RTL and testbench
===================================

Name: wm_ddr_rd_master

Overview:
- AXI read-burst master between the DDR3_50H controller read channel and the weight-memory DDR write port.
- On a start pulse it fetches a block of 256-bit weight beats from DDR, starting at a given base address.
- Each beat is streamed to the weight memory together with a sequential write address (addr_wr).
- It keeps at most one burst outstanding and flags any protocol mismatch.

Parameters:
CTRL_ADDR_WIDTH, 28, DDR controller AXI address width
DATA_WIDTH, 256, AXI data / beat width
BURST_LEN, 16, maximum beats per AXI burst (1..16; arlen is 4 bits)
WR_ADDR_WIDTH, 10, weight-memory write address width
ADDR_STEP, 8, AXI address increment per beat (256-bit beat = 8 x 32-bit DQ words)
AXI_ID, 4'd0, ID driven on axi_aruser_id and expected on axi_rid

Ports:
clk  in  1  system clock (sys_clk domain)
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  CTRL_ADDR_WIDTH  DDR start address, captured on start
beat_count  in  WR_ADDR_WIDTH+1  total beats to fetch (0..2^WR_ADDR_WIDTH), captured on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  sticky protocol error; cleared by rst or by an accepted start
axi_araddr  out  CTRL_ADDR_WIDTH  burst address
axi_aruser_id  out  4  constant AXI_ID
axi_arlen  out  4  beats-1 of the current burst
axi_arvalid  out  1  read address valid
axi_arready  in  1  read address ready
axi_rdata  in  DATA_WIDTH  read data
axi_rid  in  4  read ID
axi_rlast  in  1  last beat of burst
axi_rvalid  in  1  read data valid (no rready; every valid beat is consumed)
wm_data_out  out  DATA_WIDTH  beat to the weight memory
wm_valid_out  out  1  wm_data_out / wm_addr_wr valid
wm_addr_wr  out  WR_ADDR_WIDTH  weight-memory write address

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address, remaining-beat and burst-beat counters 0.
- IDLE
  - start=1 and beat_count!=0: capture base_addr and beat_count, clear err and the wm address counter, go to AR; busy=1 next cycle.
  - start=1 and beat_count==0: done pulses the next cycle, no AXI traffic, err cleared.
  - Any axi_rvalid arriving in IDLE is ignored.
- AR
  - axi_arvalid=1; axi_araddr = current address; axi_arlen = min(remaining, BURST_LEN)-1.
  - These values stay stable until the cycle axi_arready=1 (handshake on arvalid&arready). Then go to R and load the burst-beat counter.
  - The address advances by (arlen+1)*ADDR_STEP, modulo 2^CTRL_ADDR_WIDTH.
- R, on each axi_rvalid
  - Register axi_rdata into wm_data_out and pulse wm_valid_out in the next cycle, with wm_addr_wr = beat index. Latency: 1 cycle.
  - wm_addr_wr increments after each emitted beat and wraps modulo 2^WR_ADDR_WIDTH.
  - Decrement the burst-beat and remaining counters.
- R, end of burst (beat with axi_rlast=1)
  - remaining==0 after this beat: go to DONE.
  - Otherwise: go back to AR (minimum 1 idle cycle between bursts).
- Error checks; each sets err, and err stays set:
  - axi_rid != AXI_ID;
  - axi_rlast=1 on a beat that is not the expected last beat of the burst;
  - the expected last beat arrives with axi_rlast=0.
- Errors never stall the block: rlast ends the burst regardless, and the burst-beat counter saturates at 0.
- DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- start while busy: ignored, with no effect on counters.
- rst mid-operation: immediate return to IDLE with all outputs 0. The caller must not restart until the controller has drained the orphaned burst; beats arriving in IDLE are dropped.
- Throughput: back-to-back rvalid accepted every cycle, 1 beat/cycle.

Optional Feature:
- Macro WM_DDR_RD_PERF_CNT_EN.
- Defined: adds output rd_cycles[31:0], which counts clk cycles while busy=1.
  - Cleared on an accepted start.
  - Frozen at done, so it holds the transfer duration.
  - Saturates at 32'hFFFF_FFFF.
- Not defined: the rd_cycles port is still present but tied to 0, and no counter logic is built.

Test Plan:
- base_addr=0x100, beat_count=16, arready=1 immediately, rvalid every cycle: one burst with araddr=0x100, arlen=15; wm_addr_wr 0..15; done 1 cycle after the last wm_valid_out; err=0.
- beat_count=40, BURST_LEN=16, arready delayed 3 cycles per request: three bursts with araddr 0x000/0x080/0x100 and arlen 15/15/7; arvalid/araddr stable through the stall; 40 wm_valid_out pulses, addresses 0..39.
- Random rvalid gaps, beat_count=20: wm_valid_out count = 20, data order preserved, wm_addr_wr contiguous, busy high throughout.
- rlast asserted on beat 5 of a 16-beat burst → err=1 and the block issues the next burst; inject rid=4'd3 → err=1; a new start clears err.
- beat_count=0 → done pulses next cycle, arvalid never asserted. start pulsed while busy → no second transfer.
- rst asserted mid-burst at beat 7 → all outputs 0 next cycle; remaining rvalid beats produce no wm_valid_out. With WM_DDR_RD_PERF_CNT_EN, a 16-beat zero-stall fetch gives rd_cycles = 19 ± 1, the tolerance covering the fixed pipeline overhead.

Source files
------------

// File: rtl/wm_ddr_rd_master.sv
// AXI read-burst master: fetches a block of weight beats from DDR and streams them to the weight memory.
// Optional busy-cycle counter on rd_cycles is built only when WM_DDR_RD_PERF_CNT_EN is defined.
module wm_ddr_rd_master #(
  parameter int         CTRL_ADDR_WIDTH = 28,
  parameter int         DATA_WIDTH      = 256,
  parameter int         BURST_LEN       = 16,
  parameter int         WR_ADDR_WIDTH   = 10,
  parameter int         ADDR_STEP       = 8,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CTRL_ADDR_WIDTH-1:0] base_addr,
  input  logic [WR_ADDR_WIDTH:0]     beat_count,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  output logic [3:0]                 axi_aruser_id,
  output logic [3:0]                 axi_arlen,
  output logic                       axi_arvalid,
  input  logic                       axi_arready,
  input  logic [DATA_WIDTH-1:0]      axi_rdata,
  input  logic [3:0]                 axi_rid,
  input  logic                       axi_rlast,
  input  logic                       axi_rvalid,
  output logic [DATA_WIDTH-1:0]      wm_data_out,
  output logic                       wm_valid_out,
  output logic [WR_ADDR_WIDTH-1:0]   wm_addr_wr,
  output logic [31:0]                rd_cycles
);

  localparam logic [CTRL_ADDR_WIDTH-1:0] STEP_C    = CTRL_ADDR_WIDTH'(ADDR_STEP);
  localparam logic [WR_ADDR_WIDTH:0]     BURST_C   = (WR_ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [3:0]                 MAX_LEN_C = 4'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                       state_r, state_s;
  logic [CTRL_ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [WR_ADDR_WIDTH:0]       rem_r, rem_s;
  logic [4:0]                   beats_r, beats_s;
  logic [WR_ADDR_WIDTH-1:0]     idx_r, idx_s;
  logic                         err_r, err_s;
  logic                         done_r, done_s;
  logic                         busy_r;
  logic                         arvalid_r;
  logic [3:0]                   arlen_r, arlen_s;
  logic                         wm_valid_r, wm_valid_s;
  logic [DATA_WIDTH-1:0]        wm_data_r;
  logic [WR_ADDR_WIDTH-1:0]     wm_addr_r;
  logic [4:0]                   len_plus1_s;
  logic                         exp_last_s;

  // Next-state, counter and error logic
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    rem_s       = rem_r;
    beats_s     = beats_r;
    idx_s       = idx_r;
    err_s       = err_r;
    done_s      = 1'b0;
    wm_valid_s  = 1'b0;
    arlen_s     = arlen_r;
    len_plus1_s = {1'b0, arlen_r} + 5'd1;
    exp_last_s  = (beats_r == 5'd1);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          err_s = 1'b0;
          idx_s = '0;
          if (beat_count != '0) begin
            addr_s  = base_addr;
            rem_s   = beat_count;
            state_s = ST_AR;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (axi_arvalid && axi_arready) begin
          beats_s = len_plus1_s;
          addr_s  = addr_r + (CTRL_ADDR_WIDTH'(len_plus1_s) * STEP_C);
          state_s = ST_R;
        end else begin
          state_s = ST_AR;
        end
      end
      ST_R: begin
        if (axi_rvalid) begin
          wm_valid_s = 1'b1;
          idx_s      = idx_r + 1'b1;
          // Counters saturate so a misbehaving slave cannot wrap them
          if (beats_r != 5'd0) begin
            beats_s = beats_r - 5'd1;
          end else begin
            beats_s = 5'd0;
          end
          if (rem_r != '0) begin
            rem_s = rem_r - 1'b1;
          end else begin
            rem_s = '0;
          end
          if ((axi_rid != AXI_ID) || (axi_rlast != exp_last_s)) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          if (axi_rlast) begin
            if (rem_s == '0) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_AR;
            end
          end else begin
            state_s = ST_R;
          end
        end else begin
          state_s = ST_R;
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (rem_s >= BURST_C) begin
      arlen_s = MAX_LEN_C;
    end else begin
      arlen_s = rem_s[3:0] - 4'd1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      rem_r      <= '0;
      beats_r    <= 5'd0;
      idx_r      <= '0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      arvalid_r  <= 1'b0;
      arlen_r    <= 4'd0;
      wm_valid_r <= 1'b0;
      wm_data_r  <= '0;
      wm_addr_r  <= '0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      rem_r      <= rem_s;
      beats_r    <= beats_s;
      idx_r      <= idx_s;
      err_r      <= err_s;
      done_r     <= done_s;
      busy_r     <= (state_s != ST_IDLE);
      arvalid_r  <= (state_s == ST_AR);
      wm_valid_r <= wm_valid_s;
      if (state_s == ST_AR) begin
        arlen_r <= arlen_s;
      end
      if (wm_valid_s) begin
        wm_data_r <= axi_rdata;
        wm_addr_r <= idx_r;
      end
    end
  end

`ifdef WM_DDR_RD_PERF_CNT_EN
  logic [31:0] rd_cycles_r;

  // Busy-cycle counter: cleared on accepted start, frozen when idle, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cycles_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      rd_cycles_r <= 32'd0;
    end else if (busy_r && (rd_cycles_r != 32'hFFFF_FFFF)) begin
      rd_cycles_r <= rd_cycles_r + 32'd1;
    end
  end

  assign rd_cycles = rd_cycles_r;
`else
  assign rd_cycles = 32'd0;
`endif

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign axi_araddr    = addr_r;
  assign axi_aruser_id = AXI_ID;
  assign axi_arlen     = arlen_r;
  assign axi_arvalid   = arvalid_r;
  assign wm_data_out   = wm_data_r;
  assign wm_valid_out  = wm_valid_r;
  assign wm_addr_wr    = wm_addr_r;

endmodule

// File: tb/tb_wm_ddr_rd_master.sv
// Directed bench for wm_ddr_rd_master: bench drives the AXI slave side and scores the weight-memory stream.
module tb_wm_ddr_rd_master;
  localparam int AW = 28;
  localparam int DW = 256;
  localparam int WW = 10;

  logic          clk, rst, start;
  logic [AW-1:0] base_addr;
  logic [WW:0]   beat_count;
  logic          busy, done, err;
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_aruser_id, axi_arlen;
  logic          axi_arvalid, axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [3:0]    axi_rid;
  logic          axi_rlast, axi_rvalid;
  logic [DW-1:0] wm_data_out;
  logic          wm_valid_out;
  logic [WW-1:0] wm_addr_wr;
  logic [31:0]   rd_cycles;

  int n_vec = 0;
  int n_err = 0;
  int beat_no = 0;
  int wm_idx = 0;
  int ar_hs_cnt = 0;
  logic [WW+DW-1:0] exp_q[$];
  logic [WW+DW-1:0] obs_q[$];

  wm_ddr_rd_master dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .beat_count(beat_count),
    .busy(busy), .done(done), .err(err),
    .axi_araddr(axi_araddr), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .wm_data_out(wm_data_out), .wm_valid_out(wm_valid_out), .wm_addr_wr(wm_addr_wr),
    .rd_cycles(rd_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe the weight-memory stream and AR handshakes away from the active edge
  always @(negedge clk) begin
    if (wm_valid_out) obs_q.push_back({wm_addr_wr, wm_data_out});
    if (axi_arvalid && axi_arready) ar_hs_cnt++;
  end

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'(k) * 32'h9E37_79B1 + 32'h0000_1234;
    return {8{w}};
  endfunction

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] ba, input logic [WW:0] bc);
    start      = 1'b1;
    base_addr  = ba;
    beat_count = bc;
    step();
    start  = 1'b0;
    wm_idx = 0;
  endtask

  task automatic ar_accept(input int stall, input logic [AW-1:0] ea, input logic [3:0] el, input string tg);
    int t;
    t = 0;
    while (!axi_arvalid && t < 40) begin
      step();
      t++;
    end
    if (!axi_arvalid) begin
      check_val({tg, "_ar_timeout"}, DW'(1'b0), DW'(1'b1));
      return;
    end
    check_val({tg, "_araddr"}, DW'(axi_araddr), DW'(ea));
    check_val({tg, "_arlen"}, DW'(axi_arlen), DW'(el));
    repeat (stall) begin
      step();
      check_val({tg, "_ar_hold"}, DW'({axi_arvalid, axi_araddr, axi_arlen}), DW'({1'b1, ea, el}));
    end
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    check_val({tg, "_arv_drop"}, DW'(axi_arvalid), DW'(1'b0));
  endtask

  // rlast is raised on beat rlast_at, and on the final beat when rlast_final is set
  task automatic send_beats(input int n, input int lat, input int gapmax, input int rlast_at,
                            input logic [3:0] rid_v, input bit rlast_final);
    repeat (lat) step();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gapmax, 0)) step();
      check_val("beat_busy", DW'(busy), DW'(1'b1));
      axi_rvalid = 1'b1;
      axi_rdata  = pat(beat_no);
      axi_rid    = rid_v;
      axi_rlast  = (i == rlast_at) || ((i == n - 1) && rlast_final);
      exp_q.push_back({WW'(wm_idx), pat(beat_no)});
      beat_no++;
      wm_idx++;
      step();
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      axi_rid    = 4'd0;
    end
  endtask

  task automatic wait_done(input string tg);
    int t;
    t = 0;
    while (!done && t < 60) begin
      step();
      t++;
    end
    check_val({tg, "_done"}, DW'({done, busy}), DW'(2'b10));
  endtask

  task automatic compare_q(input string tg);
    check_val({tg, "_nbeats"}, DW'(obs_q.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_val({tg, "_addr"}, DW'(obs_q[i][DW+WW-1:DW]), DW'(exp_q[i][DW+WW-1:DW]));
      check_val({tg, "_data"}, obs_q[i][DW-1:0], exp_q[i][DW-1:0]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int h0;
    logic [31:0] rc;
    rst = 1'b1; start = 1'b0; base_addr = '0; beat_count = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rid = 4'd0; axi_rlast = 1'b0; axi_rvalid = 1'b0;
    repeat (3) step();
    check_val("reset_ctl", DW'({busy, done, err, axi_arvalid, wm_valid_out, wm_addr_wr, axi_araddr, axi_arlen, axi_aruser_id}), DW'(1'b0));
    check_val("reset_data", wm_data_out, DW'(1'b0));
    check_val("reset_rdcyc", DW'(rd_cycles), DW'(1'b0));
    rst = 1'b0;
    step();

    // Single full burst, zero stall
    pulse_start(28'h100, 11'd16);
    check_val("t1_busy", DW'(busy), DW'(1'b1));
    ar_accept(0, 28'h100, 4'd15, "t1");
    send_beats(16, 0, 0, -1, 4'd0, 1'b1);
    check_val("t1_last_wm", DW'({wm_valid_out, done, busy}), DW'(3'b101));
    step();
    check_val("t1_done", DW'({wm_valid_out, done, busy, err}), DW'(4'b0100));
    step();
    check_val("t1_done_pulse", DW'(done), DW'(1'b0));
    compare_q("t1");

    // Three bursts with AR stalls
    pulse_start(28'h000, 11'd40);
    ar_accept(3, 28'h000, 4'd15, "t2a");
    send_beats(16, 0, 0, -1, 4'd0, 1'b1);
    ar_accept(3, 28'h080, 4'd15, "t2b");
    send_beats(16, 0, 0, -1, 4'd0, 1'b1);
    ar_accept(3, 28'h100, 4'd7, "t2c");
    send_beats(8, 0, 0, -1, 4'd0, 1'b1);
    wait_done("t2");
    check_val("t2_err", DW'(err), DW'(1'b0));
    compare_q("t2");

    // Random rvalid gaps
    pulse_start(28'h2000, 11'd20);
    ar_accept(0, 28'h2000, 4'd15, "t3a");
    send_beats(16, 0, 2, -1, 4'd0, 1'b1);
    ar_accept(0, 28'h2080, 4'd3, "t3b");
    send_beats(4, 0, 2, -1, 4'd0, 1'b1);
    wait_done("t3");
    compare_q("t3");

    // Early rlast on beat 5: error, but the transfer still completes
    pulse_start(28'h400, 11'd32);
    ar_accept(0, 28'h400, 4'd15, "t4a");
    send_beats(5, 0, 0, 4, 4'd0, 1'b0);
    check_val("t4_err_early", DW'(err), DW'(1'b1));
    ar_accept(0, 28'h480, 4'd15, "t4b");
    send_beats(16, 0, 0, -1, 4'd0, 1'b1);
    ar_accept(0, 28'h500, 4'd10, "t4c");
    send_beats(11, 0, 0, -1, 4'd0, 1'b1);
    wait_done("t4");
    check_val("t4_err_sticky", DW'(err), DW'(1'b1));
    compare_q("t4");

    // Missing rlast on the expected last beat, then a stray rlast beat
    pulse_start(28'h600, 11'd2);
    check_val("t4d_err_clr", DW'(err), DW'(1'b0));
    ar_accept(0, 28'h600, 4'd1, "t4d");
    send_beats(2, 0, 0, -1, 4'd0, 1'b0);
    check_val("t4d_err_norlast", DW'({err, busy, done}), DW'(3'b110));
    send_beats(1, 0, 0, 0, 4'd0, 1'b0);
    wait_done("t4d");
    compare_q("t4d");

    // Wrong read ID
    pulse_start(28'h700, 11'd1);
    check_val("t4e_err_clr", DW'(err), DW'(1'b0));
    ar_accept(0, 28'h700, 4'd0, "t4e");
    send_beats(1, 0, 0, -1, 4'd3, 1'b1);
    wait_done("t4e");
    check_val("t4e_err_rid", DW'(err), DW'(1'b1));
    compare_q("t4e");

    // Zero-beat request
    h0 = ar_hs_cnt;
    pulse_start(28'h800, 11'd0);
    check_val("t5_zero", DW'({done, busy, axi_arvalid, err}), DW'(4'b1000));
    step();
    check_val("t5_zero_pulse", DW'({done, busy, axi_arvalid}), DW'(3'b000));
    repeat (3) step();
    check_val("t5_zero_noar", DW'(ar_hs_cnt - h0), DW'(1'b0));

    // start while busy is ignored
    h0 = ar_hs_cnt;
    pulse_start(28'h040, 11'd4);
    ar_accept(0, 28'h040, 4'd3, "t5");
    start = 1'b1; base_addr = 28'h999; beat_count = 11'd8;
    step();
    start = 1'b0;
    send_beats(4, 0, 0, -1, 4'd0, 1'b1);
    wait_done("t5");
    repeat (5) step();
    check_val("t5_no_restart", DW'({axi_arvalid, busy}), DW'(2'b00));
    check_val("t5_one_ar", DW'(ar_hs_cnt - h0), DW'(1'b1));
    compare_q("t5");

    // Reset in the middle of a burst
    pulse_start(28'h900, 11'd16);
    ar_accept(0, 28'h900, 4'd15, "t6");
    send_beats(7, 0, 0, -1, 4'd0, 1'b0);
    rst = 1'b1;
    axi_rvalid = 1'b1;
    axi_rdata  = pat(beat_no);
    step();
    check_val("t6_rst_ctl", DW'({busy, done, err, axi_arvalid, wm_valid_out, wm_addr_wr, axi_araddr, axi_arlen}), DW'(1'b0));
    check_val("t6_rst_data", wm_data_out, DW'(1'b0));
    check_val("t6_rst_rdcyc", DW'(rd_cycles), DW'(1'b0));
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      axi_rdata = pat(beat_no + 1 + i);
      axi_rlast = (i == 7);
      step();
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    step();
    check_val("t6_idle", DW'({busy, axi_arvalid, done}), DW'(3'b000));
    compare_q("t6");

    // Busy-cycle counter on a 16-beat fetch with one cycle of read latency
    pulse_start(28'hA00, 11'd16);
    ar_accept(0, 28'hA00, 4'd15, "t7");
    send_beats(16, 1, 0, -1, 4'd0, 1'b1);
    wait_done("t7");
    rc = rd_cycles;
`ifdef WM_DDR_RD_PERF_CNT_EN
    check_val("t7_rdcyc_window", DW'((rc >= 32'd18) && (rc <= 32'd20)), DW'(1'b1));
    repeat (3) step();
    check_val("t7_rdcyc_frozen", DW'(rd_cycles), DW'(rc));
`else
    check_val("t7_rdcyc_tied", DW'(rc), DW'(1'b0));
`endif
    compare_q("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
